// File: rtl/bm_c2d.sv
// bm_c2d: reads a contiguous BM word range and streams it to DRAM via one DMA write descriptor.
// Optional BM_C2D_RD_PIPE_EN: registers rd_en/rd_addr once more before the BM read port.
`ifndef BM_DEPTH
`define BM_DEPTH 256
`endif
`ifndef BM_DATA_WIDTH
`define BM_DATA_WIDTH 64
`endif
`ifndef DDR_AXIS_DATA_WIDTH
`define DDR_AXIS_DATA_WIDTH 64
`endif
`ifndef DDR_AXI_ADDR_WIDTH
`define DDR_AXI_ADDR_WIDTH 32
`endif
`ifndef DDR_LEN_WIDTH
`define DDR_LEN_WIDTH 20
`endif

module bm_c2d #(
  parameter int unsigned ADDR_W     = $clog2(`BM_DEPTH),
  parameter int unsigned DATA_W     = `BM_DATA_WIDTH,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_pulse,
  input  logic [31:0]                     c_addr,
  input  logic [31:0]                     d_addr,
  input  logic [31:0]                     n_bytes,
  output logic                            busy,
  output logic                            done_pulse,
  output logic [`DDR_AXI_ADDR_WIDTH-1:0]  dma_wr_desc_addr,
  output logic [`DDR_LEN_WIDTH-1:0]       dma_wr_desc_len,
  output logic                            dma_wr_desc_valid,
  input  logic                            dma_wr_desc_ready,
  input  logic                            dma_wr_desc_status_valid,
  output logic [`DDR_AXIS_DATA_WIDTH-1:0] dma_wr_write_data_tdata,
  output logic                            dma_wr_write_data_tvalid,
  input  logic                            dma_wr_write_data_tready,
  output logic                            dma_wr_write_data_tlast,
  output logic                            rd_en,
  output logic [ADDR_W-1:0]               rd_addr,
  input  logic [DATA_W-1:0]               dout
);

  localparam int unsigned AXI_ADDR_W = `DDR_AXI_ADDR_WIDTH;
  localparam int unsigned LEN_W      = `DDR_LEN_WIDTH;
  localparam int unsigned BYTE_SH    = $clog2(DATA_W / 8);
  localparam int unsigned CNT_W      = 32;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W     = PTR_W + 1;
  localparam int unsigned OCC_W      = PTR_W + 2;
`ifdef BM_C2D_RD_PIPE_EN
  localparam int unsigned LAT_EFF    = RD_LAT + 1;
`else
  localparam int unsigned LAT_EFF    = RD_LAT;
`endif

  typedef enum logic [1:0] {IDLE, DESC, STREAM, WAIT_STS} state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  desc_valid_q, desc_valid_d;
  logic [AXI_ADDR_W-1:0] desc_addr_q, desc_addr_d;
  logic [LEN_W-1:0]      desc_len_q, desc_len_d;
  logic [CNT_W-1:0]      n_words_q, n_words_d;
  logic [CNT_W-1:0]      rd_rem_q, rd_rem_d;
  logic [CNT_W-1:0]      beat_q, beat_d;
  logic [ADDR_W-1:0]     next_addr_q, next_addr_d;

  logic [LAT_EFF-1:0]    vld_sr_q;
  logic [DATA_W-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]     fifo_cnt_q;

  logic [CNT_W-1:0]      start_words;
  logic [OCC_W-1:0]      occupancy;
  logic                  issue, push, pop, tvalid, tlast;
  logic                  unused_c_addr_hi;

  assign unused_c_addr_hi = ^c_addr[31:ADDR_W];
  assign start_words      = n_bytes >> BYTE_SH;

  // Outstanding reads plus buffered words bound further read issue
  always_comb begin
    occupancy = OCC_W'(fifo_cnt_q);
    for (int i = 0; i < LAT_EFF; i++) begin
      occupancy = occupancy + OCC_W'(vld_sr_q[i]);
    end
  end

  assign issue  = ((state_q == DESC) || (state_q == STREAM)) && (rd_rem_q != '0) &&
                  (occupancy < OCC_W'(FIFO_DEPTH));
  assign push   = vld_sr_q[LAT_EFF-1];
  assign tvalid = (state_q == STREAM) && (fifo_cnt_q != '0);
  assign pop    = tvalid && dma_wr_write_data_tready;
  assign tlast  = tvalid && (beat_q == (n_words_q - CNT_W'(1)));

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    desc_valid_d = desc_valid_q;
    desc_addr_d  = desc_addr_q;
    desc_len_d   = desc_len_q;
    n_words_d    = n_words_q;
    rd_rem_d     = rd_rem_q;
    beat_d       = beat_q;
    next_addr_d  = next_addr_q;

    if (issue) begin
      next_addr_d = next_addr_q + ADDR_W'(1);
      rd_rem_d    = rd_rem_q - CNT_W'(1);
    end
    if (pop) begin
      beat_d = beat_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start_pulse) begin
          desc_addr_d = AXI_ADDR_W'(d_addr);
          desc_len_d  = LEN_W'(n_bytes);
          n_words_d   = start_words;
          rd_rem_d    = start_words;
          beat_d      = '0;
          next_addr_d = c_addr[ADDR_W-1:0];
          if (start_words == '0) begin
            done_d = 1'b1;
          end else begin
            state_d      = DESC;
            busy_d       = 1'b1;
            desc_valid_d = 1'b1;
          end
        end
      end
      DESC: begin
        if (dma_wr_desc_ready) begin
          desc_valid_d = 1'b0;
          state_d      = STREAM;
        end
      end
      STREAM: begin
        if (pop && tlast) begin
          state_d = WAIT_STS;
        end
      end
      WAIT_STS: begin
        if (dma_wr_desc_status_valid) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      desc_valid_q <= 1'b0;
      desc_addr_q  <= '0;
      desc_len_q   <= '0;
      n_words_q    <= '0;
      rd_rem_q     <= '0;
      beat_q       <= '0;
      next_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      desc_valid_q <= desc_valid_d;
      desc_addr_q  <= desc_addr_d;
      desc_len_q   <= desc_len_d;
      n_words_q    <= n_words_d;
      rd_rem_q     <= rd_rem_d;
      beat_q       <= beat_d;
      next_addr_q  <= next_addr_d;
    end
  end

  // Read-return tracker and prefetch FIFO pointers; reset drops in-flight reads
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      vld_sr_q[0] <= issue;
      for (int i = 1; i < LAT_EFF; i++) begin
        vld_sr_q[i] <= vld_sr_q[i-1];
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + FCNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - FCNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= dout;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && (fifo_cnt_q == FCNT_W'(FIFO_DEPTH))))
        else $error("bm_c2d: prefetch fifo overflow");
    end
  end

`ifdef BM_C2D_RD_PIPE_EN
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      rd_en_q   <= issue;
      rd_addr_q <= next_addr_q;
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
`else
  assign rd_en   = issue;
  assign rd_addr = next_addr_q;
`endif

  assign busy                     = busy_q;
  assign done_pulse               = done_q;
  assign dma_wr_desc_valid        = desc_valid_q;
  assign dma_wr_desc_addr         = desc_addr_q;
  assign dma_wr_desc_len          = desc_len_q;
  assign dma_wr_write_data_tvalid = tvalid;
  assign dma_wr_write_data_tlast  = tlast;
  assign dma_wr_write_data_tdata  = tvalid ? fifo_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_bm_c2d.sv
// tb_bm_c2d: directed + randomized bench for bm_c2d with a BM latency model and a queue-based reference.
`ifndef BM_DEPTH
`define BM_DEPTH 256
`endif
`ifndef BM_DATA_WIDTH
`define BM_DATA_WIDTH 64
`endif
`ifndef DDR_AXIS_DATA_WIDTH
`define DDR_AXIS_DATA_WIDTH 64
`endif
`ifndef DDR_AXI_ADDR_WIDTH
`define DDR_AXI_ADDR_WIDTH 32
`endif
`ifndef DDR_LEN_WIDTH
`define DDR_LEN_WIDTH 20
`endif

module tb_bm_c2d;
  localparam int unsigned ADDR_W = $clog2(`BM_DEPTH);
  localparam int unsigned DATA_W = `BM_DATA_WIDTH;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_pulse = 1'b0;
  logic [31:0] c_addr = '0, d_addr = '0, n_bytes = '0;
  logic busy, done_pulse;
  logic [`DDR_AXI_ADDR_WIDTH-1:0] dma_wr_desc_addr;
  logic [`DDR_LEN_WIDTH-1:0] dma_wr_desc_len;
  logic dma_wr_desc_valid;
  logic dma_wr_desc_ready = 1'b0;
  logic dma_wr_desc_status_valid = 1'b0;
  logic [`DDR_AXIS_DATA_WIDTH-1:0] dma_wr_write_data_tdata;
  logic dma_wr_write_data_tvalid;
  logic dma_wr_write_data_tready = 1'b1;
  logic dma_wr_write_data_tlast;
  logic rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] dout;

  bm_c2d dut (
    .clk(clk), .rst(rst), .start_pulse(start_pulse),
    .c_addr(c_addr), .d_addr(d_addr), .n_bytes(n_bytes),
    .busy(busy), .done_pulse(done_pulse),
    .dma_wr_desc_addr(dma_wr_desc_addr), .dma_wr_desc_len(dma_wr_desc_len),
    .dma_wr_desc_valid(dma_wr_desc_valid), .dma_wr_desc_ready(dma_wr_desc_ready),
    .dma_wr_desc_status_valid(dma_wr_desc_status_valid),
    .dma_wr_write_data_tdata(dma_wr_write_data_tdata),
    .dma_wr_write_data_tvalid(dma_wr_write_data_tvalid),
    .dma_wr_write_data_tready(dma_wr_write_data_tready),
    .dma_wr_write_data_tlast(dma_wr_write_data_tlast),
    .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout)
  );

  always #5 clk = ~clk;

  // BM model: fixed RD_LAT read latency, junk on the bus when not reading
  logic [DATA_W-1:0] bm [DEPTH];
  logic [DATA_W-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    pipe[0] <= rd_en ? bm[rd_addr] : DATA_W'({$urandom, $urandom});
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dout = pipe[RD_LAT-1];

  int n_assert = 0, n_fail = 0;
  int unsigned cyc = 0, mcyc = 0;
  int unsigned beats_seen, exp_nwords, desc_cnt, done_cnt, rd_cnt;
  int unsigned first_cyc, last_cyc, dwait = 0, desc_delay = 0;
  int unsigned rdy_mode = 0, stall_left = 0;
  bit last_seen, stall_done;
  logic [31:0] exp_daddr, exp_len;
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] exp_data_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Protocol monitor: rd addresses, beat data/order, tlast, stall stability, descriptor
  bit hold_q = 0, dhold_q = 0, prev_last = 0;
  logic [DATA_W-1:0] prev_data;
  logic [`DDR_AXI_ADDR_WIDTH-1:0] prev_daddr;
  logic [`DDR_LEN_WIDTH-1:0] prev_dlen;
  always @(negedge clk) begin
    mcyc++;
    if (rst) begin
      hold_q = 0;
      dhold_q = 0;
    end else begin
      if (hold_q) begin
        check("hold_tvalid", 64'(dma_wr_write_data_tvalid), 64'd1);
        check("hold_tdata", 64'(dma_wr_write_data_tdata), 64'(prev_data));
        check("hold_tlast", 64'(dma_wr_write_data_tlast), 64'(prev_last));
      end
      hold_q = dma_wr_write_data_tvalid && !dma_wr_write_data_tready;
      prev_data = dma_wr_write_data_tdata;
      prev_last = dma_wr_write_data_tlast;
      if (dhold_q) begin
        check("desc_hold_valid", 64'(dma_wr_desc_valid), 64'd1);
        check("desc_hold_addr", 64'(dma_wr_desc_addr), 64'(prev_daddr));
        check("desc_hold_len", 64'(dma_wr_desc_len), 64'(prev_dlen));
      end
      dhold_q = dma_wr_desc_valid && !dma_wr_desc_ready;
      prev_daddr = dma_wr_desc_addr;
      prev_dlen = dma_wr_desc_len;
      if (dma_wr_desc_valid) check("no_tvalid_in_desc", 64'(dma_wr_write_data_tvalid), 64'd0);
      if (dma_wr_desc_valid && dma_wr_desc_ready) begin
        desc_cnt++;
        check("desc_addr", 64'(dma_wr_desc_addr), 64'(exp_daddr));
        check("desc_len", 64'(dma_wr_desc_len), 64'(exp_len));
      end
      if (done_pulse) done_cnt++;
      if (rd_en) begin
        rd_cnt++;
        check("rd_expected", 64'(exp_addr_q.size() != 0), 64'd1);
        if (exp_addr_q.size() != 0) check("rd_addr", 64'(rd_addr), 64'(exp_addr_q.pop_front()));
      end
      if (dma_wr_write_data_tvalid && dma_wr_write_data_tready) begin
        check("beat_expected", 64'(exp_data_q.size() != 0), 64'd1);
        if (exp_data_q.size() != 0) begin
          check("tdata", 64'(dma_wr_write_data_tdata), 64'(exp_data_q.pop_front()));
          check("tlast", 64'(dma_wr_write_data_tlast), 64'(beats_seen == exp_nwords - 1));
        end
        if (beats_seen == 0) first_cyc = mcyc;
        if (dma_wr_write_data_tlast) begin
          last_seen = 1;
          last_cyc = mcyc;
        end
        beats_seen++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (dma_wr_desc_valid) dwait++; else dwait = 0;
    dma_wr_desc_ready = dma_wr_desc_valid && (dwait > desc_delay);
    case (rdy_mode)
      0: dma_wr_write_data_tready = 1'b1;
      1: begin
        if (!stall_done && beats_seen >= 6) begin
          stall_left = 20;
          stall_done = 1;
        end
        if (stall_left > 0) begin
          dma_wr_write_data_tready = 1'b0;
          stall_left--;
        end else begin
          dma_wr_write_data_tready = cyc[0];
        end
      end
      default: dma_wr_write_data_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_busy"}, 64'(busy), 64'd0);
    check({pfx, "_done"}, 64'(done_pulse), 64'd0);
    check({pfx, "_desc_valid"}, 64'(dma_wr_desc_valid), 64'd0);
    check({pfx, "_desc_addr"}, 64'(dma_wr_desc_addr), 64'd0);
    check({pfx, "_desc_len"}, 64'(dma_wr_desc_len), 64'd0);
    check({pfx, "_tvalid"}, 64'(dma_wr_write_data_tvalid), 64'd0);
    check({pfx, "_tlast"}, 64'(dma_wr_write_data_tlast), 64'd0);
    check({pfx, "_tdata"}, 64'(dma_wr_write_data_tdata), 64'd0);
    check({pfx, "_rd_en"}, 64'(rd_en), 64'd0);
    check({pfx, "_rd_addr"}, 64'(rd_addr), 64'd0);
  endtask

  // Reference: n words starting at c (mod BM size) in order, one descriptor with d/nb
  task automatic start_xfer(input logic [31:0] c, input logic [31:0] d, input logic [31:0] nb);
    logic [ADDR_W-1:0] a;
    exp_nwords = nb / BYTES;
    exp_daddr = d;
    exp_len = nb;
    beats_seen = 0; desc_cnt = 0; done_cnt = 0; rd_cnt = 0;
    last_seen = 0; stall_done = 0; stall_left = 0;
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int unsigned i = 0; i < exp_nwords; i++) begin
      a = ADDR_W'(c + i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(bm[a]);
    end
    c_addr = c; d_addr = d; n_bytes = nb;
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
  endtask

  task automatic finish_xfer(input int unsigned sts_delay, input bit thr);
    int unsigned waited = 0;
    bit fin = 0;
    for (int n = 0; n < 2000 && !fin; n++) begin
      if (last_seen && waited >= sts_delay) begin
        check("busy_in_wait", 64'(busy), 64'd1);
        check("no_early_done", 64'(done_pulse), 64'd0);
        dma_wr_desc_status_valid = 1'b1;
        tick();
        dma_wr_desc_status_valid = 1'b0;
        check("done_pulse", 64'(done_pulse), 64'd1);
        check("busy_clear", 64'(busy), 64'd0);
        fin = 1;
      end else begin
        if (last_seen) waited++;
        tick();
      end
    end
    check("xfer_complete", 64'(fin), 64'd1);
    tick();
    check("done_one_cycle", 64'(done_pulse), 64'd0);
    check("beat_count", 64'(beats_seen), 64'(exp_nwords));
    check("desc_count", 64'(desc_cnt), 64'd1);
    check("done_count", 64'(done_cnt), 64'd1);
    check("rd_all_issued", 64'(exp_addr_q.size()), 64'd0);
    if (thr) check("throughput", 64'(last_cyc - first_cyc), 64'(exp_nwords - 1));
  endtask

  initial begin
    int unsigned nw;
    for (int i = 0; i < DEPTH; i++) bm[i] = DATA_W'({$urandom, $urandom});

    rst = 1'b1;
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Basic 4-word transfer at full rate
    rdy_mode = 0; desc_delay = 0;
    start_xfer(32'h10, 32'h1000, 4 * BYTES);
    check("busy_set", 64'(busy), 64'd1);
    finish_xfer(0, 1);

    // Backpressure with a 20-cycle stall and an early status pulse that must be ignored
    rdy_mode = 1;
    start_xfer(32'h40, 32'h2000, 16 * BYTES);
    repeat (2) tick();
    dma_wr_desc_status_valid = 1'b1;
    tick();
    dma_wr_desc_status_valid = 1'b0;
    check("early_status_ignored", 64'(done_pulse), 64'd0);
    finish_xfer(2, 0);
    rdy_mode = 0;

    // Zero length
    start_xfer(32'h5, 32'h3000, 32'h0);
    check("zero_done", 64'(done_pulse), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    check("zero_desc_valid", 64'(dma_wr_desc_valid), 64'd0);
    tick();
    check("zero_done_drop", 64'(done_pulse), 64'd0);
    repeat (5) tick();
    check("zero_desc_count", 64'(desc_cnt), 64'd0);
    check("zero_rd_count", 64'(rd_cnt), 64'd0);
    check("zero_done_count", 64'(done_cnt), 64'd1);

    // BM address wrap
    start_xfer(DEPTH - 2, 32'h4000, 4 * BYTES);
    finish_xfer(1, 1);

    // Reset mid-stream, then a fresh 2-word transfer
    start_xfer(32'h20, 32'h5000, 32 * BYTES);
    for (int i = 0; i < 200 && beats_seen < 5; i++) tick();
    check("reached_5_beats", 64'(beats_seen >= 5), 64'd1);
    rst = 1'b1;
    tick();
    check_reset_vals("abort");
    rst = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    tick();
    start_xfer(32'h30, 32'h6000, 2 * BYTES);
    finish_xfer(0, 1);

    // Slow descriptor accept with a second start while busy
    desc_delay = 10;
    start_xfer(32'h60, 32'h7000, 3 * BYTES);
    repeat (3) tick();
    c_addr = 32'h90; d_addr = 32'h8000; n_bytes = 5 * BYTES;
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    check("desc_still_pending", 64'(dma_wr_desc_valid), 64'd1);
    finish_xfer(0, 1);
    repeat (12) tick();
    check("single_desc", 64'(desc_cnt), 64'd1);
    check("single_done", 64'(done_cnt), 64'd1);
    check("idle_after", 64'(busy), 64'd0);
    desc_delay = 0;

    // Random lengths, addresses and tready
    rdy_mode = 2;
    for (int k = 0; k < 4; k++) begin
      nw = $urandom_range(1, 20);
      start_xfer($urandom, $urandom, nw * BYTES);
      finish_xfer($urandom_range(0, 3), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bm_c2d.md
Name: bm_c2d

Overview:
- Stores a contiguous range of bias-memory (BM) words back to DRAM.
- Reads BM through its read port and streams the data into the DMA write controller's AXI-stream input, after issuing one write descriptor.
- Handles tready backpressure with a credit-limited prefetch FIFO.
- Sits beside the BM load path under the memory control sequencer; used for debug readback and for checkpointing on-chip bias.

Parameters:
- ADDR_W, $clog2(`BM_DEPTH), BM word address width.
- DATA_W, `BM_DATA_WIDTH, BM word width; equals `DDR_AXIS_DATA_WIDTH.
- RD_LAT, 2, BM read latency in cycles from rd_en to valid dout.
- FIFO_DEPTH, 8, prefetch FIFO entries; must be >= RD_LAT+2, power of two.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_pulse  in  1  one-cycle start
- c_addr  in  32  BM start word address (low ADDR_W bits used)
- d_addr  in  32  DRAM byte address
- n_bytes  in  32  transfer size; multiple of DATA_W/8
- busy  out  1  high from accepted start until done_pulse
- done_pulse  out  1  one-cycle completion
- dma_wr_desc_addr  out  `DDR_AXI_ADDR_WIDTH  descriptor address
- dma_wr_desc_len  out  `DDR_LEN_WIDTH  descriptor length in bytes
- dma_wr_desc_valid  out  1  descriptor valid
- dma_wr_desc_ready  in  1  descriptor accepted
- dma_wr_desc_status_valid  in  1  DMA write-completion status
- dma_wr_write_data_tdata  out  `DDR_AXIS_DATA_WIDTH  stream data
- dma_wr_write_data_tvalid  out  1  stream valid
- dma_wr_write_data_tready  in  1  stream ready
- dma_wr_write_data_tlast  out  1  last beat
- rd_en  out  1  BM read enable
- rd_addr  out  ADDR_W  BM read address
- dout  in  DATA_W  BM read data, valid RD_LAT cycles after rd_en

Behaviour:
- Reset values: busy, done_pulse, dma_wr_desc_valid, tvalid, tlast, rd_en all 0; addresses, len and tdata 0. FIFO emptied; all counters cleared; FSM set to IDLE.
- rst mid-transfer: aborts immediately; in-flight BM reads are discarded.
- FSM states: IDLE, DESC, STREAM, WAIT_STS.
- IDLE:
  - start_pulse latches c_addr, d_addr and n_bytes; n_words = n_bytes >> log2(DATA_W/8).
  - If n_words == 0: done_pulse on the next cycle, no descriptor issued, stay IDLE.
  - Otherwise go to DESC and raise busy.
- start_pulse outside IDLE is ignored.
- DESC:
  - dma_wr_desc_valid=1 with latched addr/len, held stable until dma_wr_desc_ready.
  - On the ready cycle: valid drops and FSM goes to STREAM.
  - BM reads may begin in DESC; data is not presented to the stream before STREAM.
- BM reads (in DESC or STREAM):
  - Issued when rd_remaining>0 and (inflight + fifo_count) < FIFO_DEPTH.
  - Each read drives rd_en=1, rd_addr=next_addr; then next_addr increments, wrapping modulo 2^ADDR_W.
  - inflight is tracked by an RD_LAT-deep valid shift register; a data beat is pushed into the FIFO RD_LAT cycles after its rd_en.
  - The FIFO never overflows. This is checked by assertion.
- STREAM:
  - tvalid = FIFO not empty; tdata = FIFO head.
  - tlast=1 exactly on beat n_words, counted by a beat counter.
  - Pop happens on tvalid&&tready.
  - tdata, tlast and tvalid are held stable while tvalid&&!tready.
  - Throughput: 1 beat/cycle sustained while tready=1.
  - After the tlast handshake, go to WAIT_STS.
- WAIT_STS:
  - On dma_wr_desc_status_valid: done_pulse=1 for one cycle, busy=0, FSM to IDLE.
  - Status pulses arriving in other states are ignored.
- Simultaneous FIFO push and pop in one cycle: fifo_count is unchanged.

Optional Feature:
- Macro: BM_C2D_RD_PIPE_EN.
- Defined:
  - rd_en and rd_addr pass through one extra register stage before the ports (timing closure on large BM).
  - Effective read latency becomes RD_LAT+1; the inflight tracker is lengthened to match.
  - Requires FIFO_DEPTH >= RD_LAT+3.
- Undefined: rd_en and rd_addr are driven directly from the read-issue logic.

Test Plan:
- Basic transfer: c_addr=0x10, d_addr=0x1000, n_bytes=4 words, tready=1 -> desc addr=0x1000, len=n_bytes. Beats carry BM[0x10..0x13] in order, tlast on beat 4. done_pulse one cycle after status_valid.
- Backpressure: 16 words, tready toggled 1/0 each cycle plus a 20-cycle stall -> all 16 beats delivered in order. No FIFO overflow. tdata stable during stalls.
- Zero length: n_bytes=0 -> no desc_valid, no rd_en. done_pulse exactly 1 cycle after start.
- Address wrap: c_addr=2^ADDR_W-2, 4 words -> rd_addr sequence max-1, max, 0, 1.
- Reset mid-stream: rst after 5 of 32 beats -> all outputs at reset values next cycle. A new 2-word transfer then completes correctly.
- Desc delay, ignored start: desc_ready held low 10 cycles, with a second start_pulse during busy -> single descriptor issued. Second start ignored. Exactly one done_pulse.
